// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
package spi_arb_pkg;

    // Arbiter controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

    // Slave-select codes decoded downstream into the individual ss_n lines
    localparam logic [2:0] SS_TRIG = 3'b000;
    localparam logic [2:0] SS_CH1  = 3'b001;
    localparam logic [2:0] SS_CH2  = 3'b010;
    localparam logic [2:0] SS_CH3  = 3'b011;
    localparam logic [2:0] SS_EEP  = 3'b100;
    localparam logic [2:0] SS_NONE = 3'b111;

    localparam int SPI_W = 16;
    localparam int SS_W  = 3;

    // Larger of two integers, used to size the shared cycle counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request bit after the
// last-served index (wrapping modulo NREQ) wins.
module rr_pick #(
    parameter  int NREQ = 3,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_last,
    output logic [IDW-1:0]  o_win,
    output logic            o_any
);

    logic [IDW-1:0] w_idx;

    // Scan from farthest to nearest so the candidate closest to last+1 is written last and wins
    always_comb begin
        o_any = |i_req;
        o_win = '0;
        w_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = IDW'((int'(i_last) + k) % NREQ);
            o_win = i_req[w_idx] ? w_idx : o_win;
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NREQ requesters. Issues
// one 16-bit transaction at a time, enforces a chip-select guard gap and
// aborts a transfer whose SPI_done never arrives.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter  int NREQ       = 3,
    parameter  int GAP_CYCLES = 4,
    parameter  int TIMEOUT    = 1024,
    localparam int IDW        = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [16*NREQ-1:0]    req_cmd,
    input  logic [3*NREQ-1:0]     req_ss,
    output logic [NREQ-1:0]       done,
    output logic                  err,
    output logic [SPI_W-1:0]      rd_data,
    output logic [IDW-1:0]        gnt_id,
    output logic                  busy,
    output logic                  wrt_SPI,
    output logic [SPI_W-1:0]      SPI_cmd,
    input  logic                  SPI_done,
    input  logic [SPI_W-1:0]      SPI_data_out,
    output logic [SS_W-1:0]       ss
);

    localparam int CNT_W = $clog2(max_int(TIMEOUT, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    // The IDLE cycle that follows GAP also has ss deasserted, so GAP itself
    // lasts GAP_CYCLES-1 cycles; with GAP_CYCLES==1 completion goes straight to IDLE.
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam arb_state_e AFTER_DONE     = (GAP_CYCLES > 1) ? GAP : IDLE;

    // State and registered outputs
    arb_state_e          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDW-1:0]      r_last;
    logic [IDW-1:0]      r_gnt_id;
    logic [SPI_W-1:0]    r_spi_cmd;
    logic [SS_W-1:0]     r_ss;
    logic                r_wrt;
    logic [NREQ-1:0]     r_done;
    logic                r_err;
    logic [SPI_W-1:0]    r_rd_data;
    logic                r_busy;

    // Next-state values
    arb_state_e          w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [IDW-1:0]      w_last_nxt;
    logic [IDW-1:0]      w_gnt_nxt;
    logic [SPI_W-1:0]    w_cmd_nxt;
    logic [SS_W-1:0]     w_ss_nxt;
    logic                w_wrt_nxt;
    logic [NREQ-1:0]     w_done_nxt;
    logic                w_err_nxt;
    logic [SPI_W-1:0]    w_rd_nxt;
    logic                w_busy_nxt;

    logic [IDW-1:0]      w_win;
    logic                w_any;
    logic                w_timeout;
    logic [SPI_W-1:0]    w_cmd_arr [NREQ];
    logic [SS_W-1:0]     w_ss_arr  [NREQ];

    // Unpack the per-requester command and select fields
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_cmd_arr[g] = req_cmd[SPI_W*g +: SPI_W];
        assign w_ss_arr[g]  = req_ss[SS_W*g +: SS_W];
    end

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .i_req  (req),
        .i_last (r_last),
        .o_win  (w_win),
        .o_any  (w_any)
    );

    assign w_timeout = (r_cnt == TO_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; SPI_done is only looked at in BUSY
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = ISSUE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISSUE: begin
                w_state_nxt = BUSY;
            end
            BUSY: begin
                if (SPI_done || w_timeout) begin
                    w_state_nxt = AFTER_DONE;
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = GAP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output/datapath next values; a real SPI_done wins over a coincident timeout
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_last_nxt = r_last;
        w_gnt_nxt  = r_gnt_id;
        w_cmd_nxt  = r_spi_cmd;
        w_ss_nxt   = r_ss;
        w_rd_nxt   = r_rd_data;
        w_wrt_nxt  = 1'b0;
        w_done_nxt = '0;
        w_err_nxt  = 1'b0;
        w_busy_nxt = (w_state_nxt != IDLE);
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_cmd_nxt = w_cmd_arr[w_win];
                    w_ss_nxt  = w_ss_arr[w_win];
                    w_gnt_nxt = w_win;
                end else begin
                    w_ss_nxt  = SS_NONE;
                end
                w_cnt_nxt = '0;
            end
            ISSUE: begin
                w_wrt_nxt = 1'b1;
                w_cnt_nxt = '0;
            end
            BUSY: begin
                if (SPI_done) begin
                    w_rd_nxt   = SPI_data_out;
                    w_done_nxt = NREQ'(1'b1) << r_gnt_id;
                    w_last_nxt = r_gnt_id;
                    w_ss_nxt   = SS_NONE;
                    w_cnt_nxt  = CNT_W'(1);
                end else if (w_timeout) begin
                    w_done_nxt = NREQ'(1'b1) << r_gnt_id;
                    w_err_nxt  = 1'b1;
                    w_last_nxt = r_gnt_id;
                    w_ss_nxt   = SS_NONE;
                    w_cnt_nxt  = CNT_W'(1);
                end else begin
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                end
            end
            GAP: begin
                w_ss_nxt  = SS_NONE;
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            default: begin
                w_ss_nxt  = SS_NONE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    // Datapath and output registers; last starts at NREQ-1 so requester 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_last    <= IDW'(NREQ - 1);
            r_gnt_id  <= '0;
            r_spi_cmd <= '0;
            r_ss      <= SS_NONE;
            r_wrt     <= 1'b0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_last    <= w_last_nxt;
            r_gnt_id  <= w_gnt_nxt;
            r_spi_cmd <= w_cmd_nxt;
            r_ss      <= w_ss_nxt;
            r_wrt     <= w_wrt_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_rd_data <= w_rd_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign done    = r_done;
    assign err     = r_err;
    assign rd_data = r_rd_data;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign wrt_SPI = r_wrt;
    assign SPI_cmd = r_spi_cmd;
    assign ss      = r_ss;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter (NREQ=3, GAP_CYCLES=4, TIMEOUT=1024).
module tb_spi_arbiter;

    localparam int GAP = 4;
    localparam int TO  = 1024;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [47:0] req_cmd;
    logic [8:0]  req_ss;
    logic [2:0]  done;
    logic        err;
    logic [15:0] rd_data;
    logic [1:0]  gnt_id;
    logic        busy;
    logic        wrt_SPI;
    logic [15:0] SPI_cmd;
    logic        SPI_done;
    logic [15:0] SPI_data_out;
    logic [2:0]  ss;

    int n_checks = 0;
    int n_errors = 0;

    spi_arbiter #(
        .NREQ       (3),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_cmd      (req_cmd),
        .req_ss       (req_ss),
        .done         (done),
        .err          (err),
        .rd_data      (rd_data),
        .gnt_id       (gnt_id),
        .busy         (busy),
        .wrt_SPI      (wrt_SPI),
        .SPI_cmd      (SPI_cmd),
        .SPI_done     (SPI_done),
        .SPI_data_out (SPI_data_out),
        .ss           (ss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for the start strobe
    task automatic wait_wrt();
        int k = 0;
        while (wrt_SPI !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("wrt_strobe", 32'(wrt_SPI), 32'd1);
    endtask

    // Count consecutive cycles with no slave selected, starting at the done cycle
    task automatic gap_check();
        int n = 0;
        while (ss === 3'b111 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("gap_len", 32'(n), 32'(GAP));
    endtask

    // Play the SPI master for one transaction and check the completion
    task automatic serve(input int exp_id, input logic [15:0] exp_cmd, input logic [2:0] exp_ss,
                         input int lat, input logic [15:0] data, input bit drop);
        wait_wrt();
        chk("grant_id", 32'(gnt_id), 32'(exp_id));
        chk("spi_cmd", 32'(SPI_cmd), 32'(exp_cmd));
        tick(lat);
        chk("ss_held", 32'(ss), 32'(exp_ss));
        SPI_done     = 1'b1;
        SPI_data_out = data;
        tick(1);
        SPI_done     = 1'b0;
        chk("done_onehot", 32'(done), 32'(3'b001 << exp_id));
        chk("err_clear", 32'(err), 32'd0);
        chk("rd_data", 32'(rd_data), 32'(data));
        if (drop) req = req & ~(3'b001 << exp_id);
    endtask

    initial begin
        rst_n        = 1'b0;
        req          = 3'b000;
        req_cmd      = 48'h0;
        req_ss       = 9'h1FF;
        SPI_done     = 1'b0;
        SPI_data_out = 16'h0;

        // Reset values
        tick(2);
        chk("rst_ss", 32'(ss), 32'h7);
        chk("rst_wrt", 32'(wrt_SPI), 32'd0);
        chk("rst_cmd", 32'(SPI_cmd), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rd", 32'(rd_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'(gnt_id), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // All three request right after reset: order 0,1,2 with GAP idle cycles between
        req_cmd = {16'hC002, 16'hC001, 16'hC000};
        req_ss  = {3'b011, 3'b001, 3'b000};
        req     = 3'b111;
        serve(0, 16'hC000, 3'b000, 5, 16'h0101, 1'b1);
        gap_check();
        serve(1, 16'hC001, 3'b001, 7, 16'h0202, 1'b1);
        gap_check();
        serve(2, 16'hC002, 3'b011, 4, 16'h0303, 1'b1);

        // Requester 0 keeps asking while 2 asks: 0,2,0,2
        req = 3'b101;
        serve(0, 16'hC000, 3'b000, 3, 16'h1000, 1'b0);
        serve(2, 16'hC002, 3'b011, 3, 16'h1002, 1'b0);
        serve(0, 16'hC000, 3'b000, 3, 16'h2000, 1'b0);
        serve(2, 16'hC002, 3'b011, 3, 16'h2002, 1'b0);
        req = 3'b000;
        tick(6);
        chk("idle_busy", 32'(busy), 32'd0);

        // Single request from 1: latency, select hold, data return
        req_cmd = {16'hC002, 16'hA55A, 16'hC000};
        req_ss  = {3'b011, 3'b010, 3'b000};
        req     = 3'b010;
        tick(1);
        chk("lat_wrt_early", 32'(wrt_SPI), 32'd0);
        chk("lat_ss", 32'(ss), 32'h2);
        chk("lat_busy", 32'(busy), 32'd1);
        tick(1);
        chk("lat_wrt", 32'(wrt_SPI), 32'd1);
        chk("lat_cmd", 32'(SPI_cmd), 32'hA55A);
        chk("lat_gnt", 32'(gnt_id), 32'd1);
        tick(1);
        chk("wrt_one_cycle", 32'(wrt_SPI), 32'd0);
        tick(297);
        chk("ss_hold_300", 32'(ss), 32'h2);
        SPI_done     = 1'b1;
        SPI_data_out = 16'h00C3;
        tick(1);
        SPI_done = 1'b0;
        chk("t1_done", 32'(done), 32'h2);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_rd", 32'(rd_data), 32'h00C3);
        chk("t1_ss_none", 32'(ss), 32'h7);
        req = 3'b000;
        tick(1);
        chk("t1_done_pulse", 32'(done), 32'd0);
        tick(6);

        // Async reset during BUSY
        req_cmd = {16'hC0DE, 16'hA55A, 16'h1111};
        req_ss  = {3'b100, 3'b010, 3'b000};
        req     = 3'b100;
        wait_wrt();
        chk("rstb_gnt", 32'(gnt_id), 32'd2);
        tick(10);
        rst_n = 1'b0;
        #1;
        chk("rstb_ss", 32'(ss), 32'h7);
        chk("rstb_wrt", 32'(wrt_SPI), 32'd0);
        chk("rstb_done", 32'(done), 32'd0);
        chk("rstb_busy", 32'(busy), 32'd0);
        chk("rstb_cmd", 32'(SPI_cmd), 32'd0);
        chk("rstb_rd", 32'(rd_data), 32'd0);
        req = 3'b101;
        tick(2);
        chk("rstb_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        serve(0, 16'h1111, 3'b000, 5, 16'h2222, 1'b1);
        serve(2, 16'hC0DE, 3'b100, 5, 16'h3333, 1'b1);

        // Timeout on requester 1, then requester 0 is served normally
        req_cmd = {16'hC0DE, 16'h1234, 16'h4444};
        req_ss  = {3'b100, 3'b011, 3'b000};
        req     = 3'b010;
        wait_wrt();
        chk("to_gnt", 32'(gnt_id), 32'd1);
        req = 3'b011;
        tick(TO - 1);
        chk("to_not_yet", 32'(done), 32'd0);
        chk("to_ss_held", 32'(ss), 32'h3);
        tick(1);
        chk("to_done", 32'(done), 32'h2);
        chk("to_err", 32'(err), 32'd1);
        chk("to_rd_kept", 32'(rd_data), 32'h3333);
        chk("to_ss_none", 32'(ss), 32'h7);
        req = 3'b001;
        tick(1);
        chk("to_err_pulse", 32'(err), 32'd0);
        serve(0, 16'h4444, 3'b000, 3, 16'h5555, 1'b1);
        tick(6);

        // Stray SPI_done while idle is ignored
        chk("idle_busy2", 32'(busy), 32'd0);
        SPI_done     = 1'b1;
        SPI_data_out = 16'hBEEF;
        tick(1);
        SPI_done = 1'b0;
        chk("stray_done", 32'(done), 32'd0);
        chk("stray_err", 32'(err), 32'd0);
        chk("stray_rd", 32'(rd_data), 32'h5555);
        chk("stray_busy", 32'(busy), 32'd0);

        // SPI_done on the very cycle the timeout expires counts as success
        req_cmd = {16'h6666, 16'h1234, 16'h4444};
        req_ss  = {3'b001, 3'b011, 3'b000};
        req     = 3'b100;
        wait_wrt();
        chk("tie_gnt", 32'(gnt_id), 32'd2);
        tick(TO - 1);
        chk("tie_not_yet", 32'(done), 32'd0);
        SPI_done     = 1'b1;
        SPI_data_out = 16'h5A5A;
        tick(1);
        SPI_done = 1'b0;
        chk("tie_done", 32'(done), 32'h4);
        chk("tie_err", 32'(err), 32'd0);
        chk("tie_rd", 32'(rd_data), 32'h5A5A);
        req = 3'b000;
        tick(6);
        chk("end_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
